// File: rtl/cap_charge_ctrl.sv
// Capacitor charge controller: CHARGE -> HOLD -> DISCHARGE -> DONE, with
// a cycle timeout into FAULT and abort/reset to IDLE.
//
// Ports:
//   clk        - single clock, all state on the rising edge
//   rst_n      - synchronous active-low reset
//   start      - begin a sequence (accepted in IDLE only)
//   abort      - cancel a running sequence, or clear FAULT
//   vcap       - capacitor voltage, sampled on each rising edge
//   i_drive    - drive current into the capacitor (+I / -I / 0)
//   busy       - high in CHARGE, HOLD and DISCHARGE
//   done       - one-cycle pulse when a sequence completes
//   timeout    - high while in FAULT
//   state      - encoded FSM state
//   chg_cycles - CHARGE duration captured on HOLD entry

module cap_charge_ctrl #(
   parameter real I_CHG       = 1.0e-3,
   parameter real V_TH_HI     = 1.0e-3,
   parameter real V_TH_LO     = 1.0e-4,
   parameter int  HOLD_CYC    = 8,
   parameter int  TIMEOUT_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  real         vcap,
   output real         i_drive,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [2:0]  state,
   output logic [15:0] chg_cycles
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CHARGE    = 3'd1,
      S_HOLD      = 3'd2,
      S_DISCHARGE = 3'd3,
      S_DONE      = 3'd4,
      S_FAULT     = 3'd5
   } state_t;

   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);

   state_t      st;
   state_t      nxt;
   logic [15:0] cnt;
   logic        run;
   logic        hit_to;

   assign state = st;

   // Priority inside each active state: abort, threshold, timeout.
   always_comb begin
      nxt    = st;
      run    = (st == S_CHARGE) || (st == S_HOLD) ||
               (st == S_DISCHARGE);
      hit_to = (cnt == TO_LAST);
      unique case (st)
         S_IDLE: begin
            if (start && !abort) nxt = S_CHARGE;
         end
         S_CHARGE: begin
            if (abort)                nxt = S_IDLE;
            else if (vcap >= V_TH_HI) nxt = S_HOLD;
            else if (hit_to)          nxt = S_FAULT;
         end
         S_HOLD: begin
            if (abort)                  nxt = S_IDLE;
            else if (cnt == HOLD_LAST)  nxt = S_DISCHARGE;
         end
         S_DISCHARGE: begin
            if (abort)                nxt = S_IDLE;
            else if (vcap <= V_TH_LO) nxt = S_DONE;
            else if (hit_to)          nxt = S_FAULT;
         end
         S_DONE: begin
            nxt = S_IDLE;
         end
         S_FAULT: begin
            if (abort) nxt = S_IDLE;
         end
         default: begin
            nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st         <= S_IDLE;
         cnt        <= '0;
         i_drive    <= 0.0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         chg_cycles <= '0;
      end else begin
         st <= nxt;

         if (nxt != st)
            cnt <= '0;
         else if (run)
            cnt <= cnt + 16'd1;

         if (st == S_CHARGE && nxt == S_HOLD)
            chg_cycles <= cnt + 16'd1;

         busy    <= (nxt == S_CHARGE) || (nxt == S_HOLD) ||
                    (nxt == S_DISCHARGE);
         done    <= (nxt == S_DONE);
         timeout <= (nxt == S_FAULT);

         if (nxt == S_CHARGE)
            i_drive <= I_CHG;
         else if (nxt == S_DISCHARGE)
            i_drive <= -I_CHG;
         else
            i_drive <= 0.0;
      end
   end

endmodule

// File: tb/tb_cap_charge_ctrl.sv
// Bench for cap_charge_ctrl: two instances (default and short timeout),
// each with its own capacitor model, checked against a reference model.
`timescale 1ns/1ps

module tb_cap_charge_ctrl;

   localparam real TS  = 4.0e-9;
   localparam real CAP = 100.0e-9;

   logic clk = 1'b0;
   logic rst_n, start, abort;

   real         vcap_a = 0.0, vcap_b = 0.0;
   real         i_drive_a, i_drive_b;
   logic        busy_a, busy_b, done_a, done_b, timeout_a, timeout_b;
   logic [2:0]  state_a, state_b;
   logic [15:0] chg_a, chg_b;

   int  errors = 0;
   int  checks = 0;
   bit  chk_en = 1'b0;
   int  done_tot_a = 0;

   int  m_st[2]  = '{0, 0};
   int  m_cnt[2] = '{0, 0};
   int  m_chg[2] = '{0, 0};

   always #2 clk = ~clk;

   cap_charge_ctrl u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .vcap(vcap_a), .i_drive(i_drive_a), .busy(busy_a),
      .done(done_a), .timeout(timeout_a), .state(state_a),
      .chg_cycles(chg_a)
   );

   cap_charge_ctrl #(.TIMEOUT_CYC(10)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .vcap(vcap_b), .i_drive(i_drive_b), .busy(busy_b),
      .done(done_b), .timeout(timeout_b), .state(state_b),
      .chg_cycles(chg_b)
   );

   // Capacitor models: dV = I*TS/C per clock.
   always @(posedge clk) begin
      vcap_a <= vcap_a + i_drive_a * TS / CAP;
      vcap_b <= vcap_b + i_drive_b * TS / CAP;
   end

   // Reference rules. n = cycles already spent in the current state.
   task automatic step(input int s, input int n, input int g,
                       input real v, input int to,
                       output int s2, output int n2, output int g2);
      s2 = s;
      g2 = g;
      if (!rst_n) begin
         s2 = 0;
         g2 = 0;
      end else if (s == 0) begin
         if (start && !abort) s2 = 1;
      end else if (s == 4) begin
         s2 = 0;
      end else if (s == 5) begin
         if (abort) s2 = 0;
      end else if (abort) begin
         s2 = 0;
      end else if (s == 1 && v >= 1.0e-3) begin
         s2 = 2;
         g2 = n + 1;
      end else if (s == 3 && v <= 1.0e-4) begin
         s2 = 4;
      end else if (s == 2 && n + 1 == 8) begin
         s2 = 3;
      end else if (s != 2 && n + 1 == to) begin
         s2 = 5;
      end
      n2 = (s2 == s && s >= 1 && s <= 3) ? n + 1 : 0;
   endtask

   always @(posedge clk) begin : mdl
      int s2, n2, g2;
      step(m_st[0], m_cnt[0], m_chg[0], vcap_a, 1000, s2, n2, g2);
      m_st[0]  <= s2;
      m_cnt[0] <= n2;
      m_chg[0] <= g2;
      step(m_st[1], m_cnt[1], m_chg[1], vcap_b, 10, s2, n2, g2);
      m_st[1]  <= s2;
      m_cnt[1] <= n2;
      m_chg[1] <= g2;
   end

   task automatic chk(input bit ok, input string nm, input string info);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", nm, info);
      end
   endtask

   task automatic cmp(input int k, input logic [2:0] st,
                      input logic bz, input logic dn, input logic to,
                      input logic [15:0] cg, input real id);
      int  es;
      real ei;
      bit  ok;
      es = m_st[k];
      ei = (es == 1) ? 1.0e-3 : (es == 3) ? -1.0e-3 : 0.0;
      ok = (st === 3'(es)) && (bz === (es >= 1 && es <= 3)) &&
           (dn === (es == 4)) && (to === (es == 5)) &&
           (cg === 16'(m_chg[k])) && (id == ei);
      chk(ok, $sformatf("model[%0d]", k),
          $sformatf("t=%0t got st=%0d busy=%b done=%b to=%b chg=%0d i=%g exp st=%0d chg=%0d i=%g",
                    $time, st, bz, dn, to, cg, id, es, m_chg[k], ei));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, state_a, busy_a, done_a, timeout_a, chg_a, i_drive_a);
         cmp(1, state_b, busy_b, done_b, timeout_b, chg_b, i_drive_b);
         if (done_a) done_tot_a++;
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit rst_vals_a();
      return state_a == 3'd0 && i_drive_a == 0.0 && !busy_a &&
             !done_a && !timeout_a && chg_a == 16'd0;
   endfunction

   function automatic bit rst_vals_b();
      return state_b == 3'd0 && i_drive_b == 0.0 && !busy_b &&
             !done_b && !timeout_b && chg_b == 16'd0;
   endfunction

   initial begin : stim
      int  na_hold, nb_chg, ndone, nd, d0;
      bit  hold_seen, b_seen, done_seen, seen4, found;
      real vprev, vhold;

      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      chk(rst_vals_a(), "reset_a", $sformatf("st=%0d chg=%0d i=%g",
          state_a, chg_a, i_drive_a));
      chk(rst_vals_b(), "reset_b", $sformatf("st=%0d chg=%0d i=%g",
          state_b, chg_b, i_drive_b));

      // Full sequence; start on the first edge after release.
      rst_n = 1'b1;
      start = 1'b1;
      na_hold = 0; nb_chg = 0; ndone = 0;
      hold_seen = 0; b_seen = 0; done_seen = 0;
      vprev = vcap_a;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == 0)
            chk(state_a == 3'd1, "first_edge_start",
                $sformatf("st=%0d exp 1", state_a));
         if (state_b == 3'd1) nb_chg++;
         if (state_b == 3'd5 && !b_seen) begin
            b_seen = 1;
            chk(nb_chg == 10, "b_charge_len",
                $sformatf("got %0d exp 10", nb_chg));
            chk(timeout_b && i_drive_b == 0.0, "b_fault_out",
                $sformatf("to=%b i=%g exp 1 0", timeout_b, i_drive_b));
         end
         if (state_a == 3'd2 && !hold_seen) begin
            hold_seen = 1;
            chk(vprev >= 1.0e-3 && vprev <= 1.04e-3 + 1.0e-12,
                "a_hold_vcap", $sformatf("got %g exp 1e-3..1.04e-3", vprev));
            chk(chg_a >= 16'd25 && chg_a <= 16'd28, "a_chg_cycles",
                $sformatf("got %0d exp 25..28", chg_a));
         end
         if (state_a == 3'd2) na_hold++;
         if (state_a == 3'd4 && !done_seen) begin
            done_seen = 1;
            chk(vprev <= 1.0e-4, "a_dis_vcap",
                $sformatf("got %g exp <=1e-4", vprev));
         end
         if (done_a) ndone++;
         if (done_seen && state_a == 3'd0) break;
         vprev = vcap_a;
      end
      chk(done_seen && state_a == 3'd0, "a_seq_end",
          $sformatf("done_seen=%b st=%0d", done_seen, state_a));
      chk(na_hold == 8, "a_hold_len", $sformatf("got %0d exp 8", na_hold));
      chk(ndone == 1, "a_done_pulses", $sformatf("got %0d exp 1", ndone));
      chk(b_seen, "b_fault_seen", $sformatf("got %b exp 1", b_seen));

      // Abort clears FAULT.
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk(state_b == 3'd0 && !timeout_b, "b_fault_clear",
          $sformatf("st=%0d to=%b exp 0 0", state_b, timeout_b));

      // Abort at CHARGE cycle 5.
      d0 = done_tot_a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk(state_a == 3'd1, "a_charge5", $sformatf("st=%0d exp 1", state_a));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk(state_a == 3'd0 && i_drive_a == 0.0 && !busy_a, "a_abort",
          $sformatf("st=%0d i=%g busy=%b", state_a, i_drive_a, busy_a));
      vhold = vcap_a;
      repeat (3) @(negedge clk);
      chk(vcap_a == vhold, "a_vcap_holds",
          $sformatf("got %g exp %g", vcap_a, vhold));
      chk(done_tot_a == d0, "a_no_done",
          $sformatf("got %0d exp %0d", done_tot_a, d0));

      // Reset during DISCHARGE.
      start = 1'b1;
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (state_a == 3'd3) begin
            found = 1;
            break;
         end
      end
      chk(found, "a_reach_dis", $sformatf("st=%0d exp 3", state_a));
      rst_n = 1'b0;
      @(negedge clk);
      chk(rst_vals_a(), "a_reset_dis", $sformatf("st=%0d chg=%0d i=%g",
          state_a, chg_a, i_drive_a));
      chk(rst_vals_b(), "b_reset_any", $sformatf("st=%0d chg=%0d i=%g",
          state_b, chg_b, i_drive_b));
      rst_n = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk(state_a == 3'd1, "a_start_after_rst",
          $sformatf("st=%0d exp 1", state_a));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // start+abort together, then start held through a sequence.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      chk(state_a == 3'd0 && state_b == 3'd0, "start_abort_idle",
          $sformatf("st=%0d/%0d exp 0", state_a, state_b));
      abort = 1'b0;
      nd = 0;
      seen4 = 0;
      found = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done_a) nd++;
         if (state_a == 3'd4) seen4 = 1;
         else if (seen4 && state_a == 3'd0) begin
            found = 1;
            break;
         end
      end
      chk(found, "a_held_idle", $sformatf("st=%0d exp 0", state_a));
      @(negedge clk);
      chk(state_a == 3'd1, "a_restart", $sformatf("st=%0d exp 1", state_a));
      chk(nd == 1, "a_held_done", $sformatf("got %0d exp 1", nd));
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom % 8) == 0;
         abort = ($urandom % 40) == 0;
         rst_n = ($urandom % 300) != 0;
      end
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
